button_event: RTL
=================

BUTTON_EVENT -- requirements
Module: button_event

Interface
REQ-001 Parameter LONG_CYCLES, default 50000000: cycles the button must stay high to count as a long press.
REQ-002 Parameter DCLICK_CYCLES, default 25000000: maximum gap, in cycles, between the first release and the second press of a double click.
REQ-003 Parameter REPEAT_CYCLES, default 10000000: auto-repeat period while long-held; used only under REQ-024.
REQ-004 clk  input  1: the only clock; all logic is on its rising edge.
REQ-005 rst  input  1: reset; synchronous and active-high.
REQ-006 btn_level  input  1: debounced button level from the upstream debounce stage; 1 = pressed.
REQ-007 click_pulse  output  1: one-cycle strobe for a confirmed single click.
REQ-008 dclick_pulse  output  1: one-cycle strobe for a double click.
REQ-009 long_pulse  output  1: one-cycle strobe when the long-press threshold is reached.
REQ-010 held  output  1: level; high while in LONG state.

Function
REQ-011 The block SHALL register btn_level into prev_level; rise = btn_level & ~prev_level; fall = ~btn_level & prev_level.
REQ-012 The FSM SHALL have exactly these states: IDLE, PRESS1, GAP, PRESS2, LONG.
REQ-013 IDLE: on rise, go to PRESS1 and clear cnt.
REQ-014 PRESS1, fall before the threshold: go to GAP and clear cnt.
REQ-015 PRESS1, otherwise: cnt increments; when cnt == LONG_CYCLES-1 with btn_level high, go to LONG and assert long_pulse.
REQ-016 LONG: held = 1; on fall, go to IDLE; no click is reported.
REQ-017 GAP, rise while cnt < DCLICK_CYCLES-1: go to PRESS2 and assert dclick_pulse.
REQ-018 GAP, cnt reaches DCLICK_CYCLES-1 with no rise: assert click_pulse and go to IDLE.
REQ-019 GAP, rise and timeout in the same cycle: rise wins, giving dclick_pulse only.
REQ-020 PRESS2: wait for fall, then go to IDLE; no long detection applies to the second press.
REQ-021 All outputs SHALL be registered; each pulse is high for exactly one cycle, in the cycle after the input sample that triggers it.
REQ-022 cnt SHALL be $clog2(max(LONG_CYCLES, DCLICK_CYCLES, REPEAT_CYCLES))+1 bits wide, unsigned, and SHALL saturate rather than wrap.
REQ-023 At most one of click_pulse, dclick_pulse and long_pulse SHALL be high in any cycle.

Configuration
REQ-024 With macro BUTTON_EVENT_REPEAT_EN defined, LONG SHALL re-assert long_pulse every REPEAT_CYCLES cycles while btn_level stays high, using a separate repeat counter that restarts on each pulse.
REQ-025 With BUTTON_EVENT_REPEAT_EN undefined, long_pulse SHALL fire once per press and no repeat counter SHALL be synthesized.

Reset
REQ-026 When rst = 1 at a clock edge: state = IDLE, cnt = 0, all pulses = 0, held = 0, prev_level = 1.
REQ-027 rst SHALL override every other input in the same cycle.
REQ-028 A button already held at reset release SHALL NOT produce a rise; it needs a release and a new press.
REQ-029 Reset asserted mid-press or mid-gap SHALL discard the pending event silently.

Structure
REQ-030 Package button_event_pkg SHALL hold the state enum (IDLE, PRESS1, GAP, PRESS2, LONG) and the counter-width function.
REQ-031 Sub-module btn_edge_det SHALL implement prev_level and rise/fall detection (REQ-011, with the reset value of REQ-026); the FSM and counters stay in button_event.

Verification
REQ-032 The bench SHALL cover the following directed scenarios, using LONG_CYCLES=8, DCLICK_CYCLES=4, REPEAT_CYCLES=3:
- High 3 cycles, then low -> click_pulse once, 4 cycles after the fall; no other pulse.
- High 3, low 2, high 2, low -> dclick_pulse once, the cycle after the second rise; click_pulse never.
- High 12 cycles -> long_pulse in the cycle after the 8th high sample; held high until the cycle after the fall; no click.
- With REPEAT_EN, high 20 cycles -> long_pulse at cycles 9, 12, 15, 18; without REPEAT_EN -> only at cycle 9.
- rst pulsed while btn_level = 1 mid-PRESS1, then held high 12 cycles -> no pulses until a release followed by a new press.
- Rise on the same cycle the GAP timeout would fire -> dclick_pulse = 1, click_pulse = 0.

Source files
------------

// File: rtl/button_event_pkg.sv
// Shared types and sizing helpers for the button event classifier.
// Optional auto-repeat in the top is enabled by BUTTON_EVENT_REPEAT_EN.
package button_event_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    GAP    = 3'd2,
    PRESS2 = 3'd3,
    LONG   = 3'd4
  } state_t;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // One spare bit above the largest terminal count.
  function automatic int cnt_width(
    input int a,
    input int b,
    input int c
  );
    return $clog2(max3(a, b, c)) + 1;
  endfunction

endpackage

// File: rtl/btn_edge_det.sv
// Registers the debounced level and derives rise/fall strobes.
// prev resets high so a button held through reset never looks like a press.
module btn_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_prev;

  // Previous-sample register; reset high to mask a held button.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= 1'b1;
    end else begin
      r_prev <= i_level;
    end
  end

  assign o_rise = i_level & ~r_prev;
  assign o_fall = ~i_level & r_prev;

endmodule

// File: rtl/button_event.sv
// Classifies a debounced button into click, double click and long press.
// Define BUTTON_EVENT_REPEAT_EN for periodic long_pulse while held.
module button_event
  import button_event_pkg::*;
#(
  parameter int LONG_CYCLES   = 50000000,
  parameter int DCLICK_CYCLES = 25000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_level,
  output logic click_pulse,
  output logic dclick_pulse,
  output logic long_pulse,
  output logic held
);

  localparam int CW = cnt_width(
    LONG_CYCLES, DCLICK_CYCLES, REPEAT_CYCLES
  );
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] DCLK_LAST = CW'(DCLICK_CYCLES - 1);

  logic          w_rise;
  logic          w_fall;
  logic          w_rpt_fire;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_cnt_inc;
  logic          w_click_nxt;
  logic          w_dclick_nxt;
  logic          w_long_nxt;

  btn_edge_det u_edge (
    .clk     (clk),
    .rst     (rst),
    .i_level (btn_level),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  // Saturating increment; the counter never wraps.
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

`ifdef BUTTON_EVENT_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES) + 1;
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] r_rcnt;

  assign w_rpt_fire = (r_state == LONG) && btn_level
                    && (r_rcnt >= RPT_LAST);

  // Repeat counter runs only in LONG and restarts on each pulse.
  always_ff @(posedge clk) begin
    if (rst || (r_state != LONG) || w_rpt_fire) begin
      r_rcnt <= '0;
    end else if (r_rcnt != '1) begin
      r_rcnt <= r_rcnt + 1'b1;
    end
  end
`else
  assign w_rpt_fire = 1'b0;
`endif

  // Next-state, counter and pulse decode for the click classifier.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_click_nxt  = 1'b0;
    w_dclick_nxt = 1'b0;
    w_long_nxt   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_state_nxt = PRESS1;
          w_cnt_nxt   = '0;
        end
      end
      PRESS1: begin
        if (w_fall) begin
          w_state_nxt = GAP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          // Compare the incremented count so the pulse lands
          // right after the LONG_CYCLES-th high sample.
          if (btn_level && (w_cnt_inc >= LONG_LAST)) begin
            w_state_nxt = LONG;
            w_long_nxt  = 1'b1;
          end
        end
      end
      GAP: begin
        // A rise on the timeout cycle still counts as a double.
        if (w_rise) begin
          w_state_nxt  = PRESS2;
          w_dclick_nxt = 1'b1;
          w_cnt_nxt    = '0;
        end else if (r_cnt >= DCLK_LAST) begin
          w_state_nxt = IDLE;
          w_click_nxt = 1'b1;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      PRESS2: begin
        if (w_fall) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      end
      LONG: begin
        if (w_fall) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (w_rpt_fire) begin
          w_long_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, counter and registered outputs; reset drops any pending event.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      click_pulse  <= 1'b0;
      dclick_pulse <= 1'b0;
      long_pulse   <= 1'b0;
      held         <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      click_pulse  <= w_click_nxt;
      dclick_pulse <= w_dclick_nxt;
      long_pulse   <= w_long_nxt;
      held         <= (w_state_nxt == LONG);
    end
  end

endmodule
